// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered CH-to-1 multiplexer with a manual select mode and
// a round-robin scan mode that dwells DWELL cycles on each eligible channel.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in         packed channel data, channel k at [k*WIDTH +: WIDTH]
//   sel        channel select used in manual mode
//   mode       0 = manual, 1 = scan
//   en         block enable (has priority over mode)
//   ch_mask    bit k = 1 makes channel k eligible for scanning
//   out        registered selected data
//   out_ch     index of the channel currently driving out
//   out_valid  out holds legitimate channel data
//   wrap       one-cycle pulse when the scan returns to the lowest eligible channel
//   out_par    (only with MUX_SCAN_REG_PARITY_EN) XOR reduction of out,
//              registered alongside it
//
// Optional feature macro: MUX_SCAN_REG_PARITY_EN

module mux_scan_reg #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int DWELL = 1,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*WIDTH-1:0]   in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  en,
  input  logic [CH-1:0]         ch_mask,
  output logic [WIDTH-1:0]      out,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
`ifdef MUX_SCAN_REG_PARITY_EN
  output logic                  wrap,
  output logic                  out_par
`else
  output logic                  wrap
`endif
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  localparam logic [SEL_W:0] CH_LIM     = (SEL_W+1)'(CH);
  localparam logic [7:0]     DWELL_LAST = 8'(DWELL - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
`ifdef MUX_SCAN_REG_PARITY_EN
  logic               par_q, par_d;
`endif

  logic [SEL_W-1:0]   lowest;
  logic               any_elig;
  logic [SEL_W-1:0]   next_above;
  logic               has_above;
  logic               sel_ok;

  // Lowest eligible channel and the nearest eligible channel above the
  // current pointer; scanning downward lets the smallest match win.
  always_comb begin
    lowest     = '0;
    any_elig   = 1'b0;
    next_above = '0;
    has_above  = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lowest   = SEL_W'(i);
        any_elig = 1'b1;
        if (i > int'(ptr_q)) begin
          next_above = SEL_W'(i);
          has_above  = 1'b1;
        end
      end
    end
  end

  // Only matters for non-power-of-2 CH, where sel can name a missing channel.
  assign sel_ok = ({1'b0, sel} < CH_LIM);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    out_ch_d = out_ch_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!mode) begin
      state_d = MANUAL;
      cnt_d   = '0;
      if (sel_ok) begin
        out_d    = in[int'(sel)*WIDTH +: WIDTH];
        out_ch_d = sel;
        valid_d  = 1'b1;
      end
    end else if (!any_elig) begin
      // No eligible channel: park in IDLE so a restored mask re-enters the
      // scan at its lowest channel instead of finishing a stale dwell.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (state_q != SCAN) begin
        state_d = SCAN;
        ptr_d   = lowest;
        cnt_d   = '0;
      end else if (cnt_q == DWELL_LAST) begin
        // Dwell complete; a masked current pointer still gets here, then moves on.
        cnt_d  = '0;
        ptr_d  = has_above ? next_above : lowest;
        wrap_d = !has_above;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      out_d    = in[int'(ptr_d)*WIDTH +: WIDTH];
      out_ch_d = ptr_d;
      valid_d  = 1'b1;
    end
  end

`ifdef MUX_SCAN_REG_PARITY_EN
  // out_d equals out_q whenever out is held, so parity holds with it.
  assign par_d = ^out_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      out_ch_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
`ifdef MUX_SCAN_REG_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      out_ch_q <= out_ch_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
`ifdef MUX_SCAN_REG_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;
`ifdef MUX_SCAN_REG_PARITY_EN
  assign out_par   = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: directed plus randomized bench for mux_scan_reg
// (CH=4, WIDTH=8, DWELL=3), checked against a behavioural channel-list model.

module tb_mux_scan_reg;

  localparam int WIDTH = 8;
  localparam int CH    = 4;
  localparam int DWELL = 3;
  localparam int SEL_W = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [CH*WIDTH-1:0] in_v;
  logic [SEL_W-1:0]    sel;
  logic                mode;
  logic                en;
  logic [CH-1:0]       ch_mask;
  logic [WIDTH-1:0]    out;
  logic [SEL_W-1:0]    out_ch;
  logic                out_valid;
  logic                wrap;
`ifdef MUX_SCAN_REG_PARITY_EN
  logic                out_par;
`endif

  always #5 clk = ~clk;

  mux_scan_reg #(.WIDTH(WIDTH), .CH(CH), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_v),
    .sel       (sel),
    .mode      (mode),
    .en        (en),
    .ch_mask   (ch_mask),
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
`ifdef MUX_SCAN_REG_PARITY_EN
    .wrap      (wrap),
    .out_par   (out_par)
`else
    .wrap      (wrap)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the channel being shown, how many cycles it has
  // been shown so far, and whether a scan is in progress.
  int m_out   = 0;
  int m_ch    = 0;
  int m_valid = 0;
  int m_wrap  = 0;
  int m_scan  = 0;
  int m_shown = 0;

  function automatic int chan_val(int k);
    return int'((in_v >> (k * WIDTH)) & 32'hFF);
  endfunction

  function automatic int parity8(int v);
    int p = 0;
    for (int b = 0; b < 8; b++) p = p ^ ((v >> b) & 1);
    return p;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int elig[$];
    int found;
    if (rst) begin
      m_out = 0; m_ch = 0; m_valid = 0; m_wrap = 0; m_scan = 0; m_shown = 0;
      return;
    end
    m_wrap  = 0;
    m_valid = 0;
    if (!en) begin
      m_scan = 0;
    end else if (!mode) begin
      m_scan = 0;
      if (int'(sel) < CH) begin
        m_ch = int'(sel); m_out = chan_val(m_ch); m_valid = 1;
      end
    end else begin
      for (int k = 0; k < CH; k++) if (ch_mask[k]) elig.push_back(k);
      if (elig.size() == 0) begin
        m_scan = 0;
      end else begin
        if (!m_scan) begin
          m_scan = 1; m_ch = elig[0]; m_shown = 1;
        end else if (m_shown == DWELL) begin
          found = -1;
          foreach (elig[j]) if (found < 0 && elig[j] > m_ch) found = elig[j];
          if (found < 0) begin
            m_ch = elig[0]; m_wrap = 1;
          end else begin
            m_ch = found;
          end
          m_shown = 1;
        end else begin
          m_shown++;
        end
        m_out = chan_val(m_ch); m_valid = 1;
      end
    end
  endtask

  task automatic compare_model();
    check_output("out", 32'(out), 32'(m_out));
    check_output("out_ch", 32'(out_ch), 32'(m_ch));
    check_output("out_valid", 32'(out_valid), 32'(m_valid));
    check_output("wrap", 32'(wrap), 32'(m_wrap));
`ifdef MUX_SCAN_REG_PARITY_EN
    check_output("out_par", 32'(out_par), 32'(parity8(m_out)));
`endif
  endtask

  task automatic apply_stimulus();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  int exp_seq [12] = '{0, 0, 0, 1, 1, 1, 3, 3, 3, 0, 0, 0};
  int k;
  bit seen;

  initial begin
    $display("[TB] start");
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; ch_mask = '0;
    in_v = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    apply_stimulus();
    apply_stimulus();
    check_output("rst_out", 32'(out), 32'h0);
    check_output("rst_valid", 32'(out_valid), 32'h0);

    // Manual sweep
    rst = 1'b0; en = 1'b1; mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = SEL_W'(s);
      apply_stimulus();
      check_output("man_out", 32'(out), 32'(8'hAA + 8'h11 * s));
      check_output("man_ch", 32'(out_ch), 32'(s));
      check_output("man_valid", 32'(out_valid), 32'h1);
    end

    // Scan with dwell 3 over mask 1011
    mode = 1'b1; ch_mask = 4'b1011;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus();
      check_output("scan_ch", 32'(out_ch), 32'(exp_seq[i]));
      check_output("scan_wrap", 32'(wrap), (i == 9) ? 32'h1 : 32'h0);
    end

    // Empty mask, then restore a single channel
    ch_mask = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus();
      check_output("empty_valid", 32'(out_valid), 32'h0);
    end
    ch_mask = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < DWELL + 1 && !seen; i++) begin
      apply_stimulus();
      if (out_valid === 1'b1 && out_ch === 2'd2) seen = 1'b1;
    end
    check_output("restore_ch2", 32'(seen), 32'h1);

    // Reset mid-scan while on channel 3
    ch_mask = 4'b1010;
    k = 0;
    while (out_ch !== 2'd3 && k < 20) begin
      apply_stimulus();
      k++;
    end
    check_output("reach_ch3", 32'(out_ch), 32'h3);
    rst = 1'b1;
    apply_stimulus();
    check_output("midrst_out", 32'(out), 32'h0);
    check_output("midrst_ch", 32'(out_ch), 32'h0);
    check_output("midrst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    apply_stimulus();
    check_output("restart_ch", 32'(out_ch), 32'h1);

    // Enable and mode switching
    en = 1'b0;
    apply_stimulus();
    check_output("dis_valid", 32'(out_valid), 32'h0);
    en = 1'b1; mode = 1'b0; sel = 2'd2;
    apply_stimulus();
    check_output("en_man_out", 32'(out), 32'hCC);
    mode = 1'b1;
    apply_stimulus();
    check_output("to_scan_ch", 32'(out_ch), 32'h1);

`ifdef MUX_SCAN_REG_PARITY_EN
    mode = 1'b0; in_v = {8'hDD, 8'hCC, 8'h07, 8'hAA};
    sel = 2'd0;
    apply_stimulus();
    check_output("par_aa", 32'(out_par), 32'h0);
    sel = 2'd1;
    apply_stimulus();
    check_output("par_07", 32'(out_par), 32'h1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 3) != 0);
      sel  = SEL_W'($urandom_range(0, CH - 1));
      if ($urandom_range(0, 7) == 0) ch_mask = CH'($urandom_range(0, 15));
      in_v = $urandom();
      apply_stimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
- Parametrised, registered N-channel to 1 multiplexer. It is the clocked successor of the team's combinational 4:1 mux.
- Two modes:
  - Manual: an externally driven select.
  - Scan: an internal round-robin scanner that dwells a programmable number of cycles per channel and skips masked channels.
- Sits in front of shared serial or display paths that time-share one datapath across several sources.

Parameters:
- WIDTH, 8, data bits per channel.
- CH, 4, number of input channels (legal range 2..16).
- DWELL, 1, cycles spent on each channel in scan mode (legal range 1..255).
- Derived localparam SEL_W = $clog2(CH). Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in  in  CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  channel select, used in manual mode.
- mode  in  1  0 = manual, 1 = scan.
- en  in  1  block enable.
- ch_mask  in  CH  bit k = 1 means channel k is eligible in scan mode.
- out  out  WIDTH  registered selected data.
- out_ch  out  SEL_W  index of the channel currently driving out.
- out_valid  out  1  out holds legitimate channel data.
- wrap  out  1  one-cycle pulse when the scan returns to the lowest eligible channel.

Behaviour:
- Reset is synchronous and active-high, and overrides everything.
  - out=0, out_ch=0, out_valid=0, wrap=0.
  - Dwell counter = 0; scan pointer = 0; state = IDLE.
- Reset asserted mid-scan returns the block to these values on the next edge. Scanning restarts from the lowest eligible channel.
- Latency: exactly 1 cycle from in/sel change to out in manual mode. Output is fully registered, with no combinational path from inputs to outputs.
- State machine: IDLE, MANUAL, SCAN.
  - IDLE: entered when en=0. Outputs out/out_ch are held, out_valid=0, wrap=0. Leaves IDLE on en=1: to MANUAL if mode=0, to SCAN if mode=1.
  - MANUAL: every cycle, out <= in[sel], out_ch <= sel, out_valid <= 1. If sel >= CH (non-power-of-2 CH), out/out_ch are held and out_valid <= 0.
  - SCAN:
    - On entry, the pointer loads the lowest set bit of ch_mask and the dwell counter clears.
    - Every cycle, out <= in[pointer], out_ch <= pointer, out_valid <= 1.
    - The dwell counter increments each cycle. When it reaches DWELL-1 it clears and the pointer advances to the next set bit of ch_mask above the current pointer, wrapping to the lowest set bit.
    - wrap pulses (registered, aligned with the first out cycle of the new channel) when the advance wraps.
    - Single eligible channel: pointer stays, and wrap pulses every DWELL cycles.
    - ch_mask = 0: out/out_ch held, out_valid=0, no wrap.
    - ch_mask changes take effect at the next advance. If the current pointer becomes masked, the block still completes its dwell, then advances.
- Mode change while en=1: transition happens on the next edge.
  - MANUAL->SCAN restarts from the lowest eligible channel.
  - SCAN->MANUAL abandons the dwell count.
- en=0 has priority over mode.
- DWELL=1: pointer advances every cycle.

Optional Feature:
- Macro: MUX_SCAN_REG_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit), the even parity (XOR reduction) of the data registered into out.
  - out_par is registered in the same cycle as out.
  - Reset value 0; held whenever out is held.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Manual sweep:
  - Setup: CH=4, WIDTH=8, in = {8'hDD,8'hCC,8'hBB,8'hAA}, en=1, mode=0.
  - Stimulus: sel=0,1,2,3, one per cycle.
  - Response: out = AA,BB,CC,DD, each one cycle after its sel; out_ch matches; out_valid=1.
- Scan with dwell and mask:
  - Setup: DWELL=3, ch_mask=4'b1011, mode=1.
  - Response: out_ch sequence 0,0,0,1,1,1,3,3,3,0…; wrap=1 only on the first cycle of each return to 0.
- Empty mask:
  - Stimulus: ch_mask=0 in scan.
  - Response: out_valid=0 and out held. Restoring ch_mask=4'b0100 gives out_ch=2 with out_valid=1 within DWELL+1 cycles.
- Reset mid-scan:
  - Stimulus: assert rst for 1 cycle while out_ch=3.
  - Response: next edge gives out=0, out_ch=0, out_valid=0, wrap=0. After release, scan restarts at the lowest eligible channel.
- Enable and mode switching:
  - Stimulus: en=0.
  - Response: out_valid=0 and out held. Then en=1, mode=0, sel=2 gives out=CC next cycle. Then mode=1 gives out_ch = lowest mask bit next cycle.
- Parity (MUX_SCAN_REG_PARITY_EN defined):
  - Stimulus: select 8'hAA, then 8'h07.
  - Response: out_par = 0, then 1, each aligned with out.
